// File: rtl/bp_core_stall_counters.sv
// bp_core_stall_counters
//   Per-core stall-attribution counter bank. Per-stage stall-event vectors
//   are ORed down a shadow pipeline. At the last stage the lowest set reason
//   bit is charged for each non-retiring, unfrozen cycle. A snapshot copies
//   the live bank into a shadow bank. The shadow bank is read through a
//   valid/ready port with a yumi handshake on the returned data.
//
//   Optional build macro: BP_STALL_COUNTERS_SATURATE_EN
//     defined   -> live counters saturate at all-ones. overflow_o sets when
//                  a counter reaches all-ones.
//     undefined -> live counters wrap to zero. overflow_o sets on the wrap.
//
// Ports
//   clk_i, reset_i    clock, asynchronous active-high reset
//   freeze_i          core frozen. Takes effect num_stages_p+1 cycles later.
//   stage_event_i     stage s event vector at [s*num_reasons_p +: num_reasons_p]
//   instret_i         instruction retired this cycle
//   snapshot_i        live -> shadow, then live restarts from this cycle's increments
//   clear_i           zero both banks, the pipeline and overflow_o (wins over snapshot_i)
//   rd_v_i, rd_addr_i, rd_ready_and_o   read request. Addresses:
//                     0..num_reasons_p-1 = reasons, num_reasons_p = cycles,
//                     num_reasons_p+1 = instret, anything else reads 0.
//   rd_data_v_o, rd_data_o, rd_data_yumi_i   read response
//   overflow_o        sticky live-bank overflow flag
module bp_core_stall_counters #(
  parameter int num_stages_p = 7,
  parameter int num_reasons_p = 27,
  parameter int cnt_width_p = 32,
  localparam int addr_width_lp = $clog2(num_reasons_p + 2)
) (
  input  logic                                   clk_i,
  input  logic                                   reset_i,
  input  logic                                   freeze_i,
  input  logic [num_stages_p*num_reasons_p-1:0]  stage_event_i,
  input  logic                                   instret_i,
  input  logic                                   snapshot_i,
  input  logic                                   clear_i,
  input  logic                                   rd_v_i,
  input  logic [addr_width_lp-1:0]               rd_addr_i,
  output logic                                   rd_ready_and_o,
  output logic                                   rd_data_v_o,
  output logic [cnt_width_p-1:0]                 rd_data_o,
  input  logic                                   rd_data_yumi_i,
  output logic                                   overflow_o
);

  localparam int num_cnt_lp = num_reasons_p + 2;
  localparam int cyc_idx_lp = num_reasons_p;
  localparam int ret_idx_lp = num_reasons_p + 1;
  localparam logic [cnt_width_p-1:0] max_lp = '1;
  localparam logic [cnt_width_p-1:0] one_lp = cnt_width_p'(1);

  // Freeze delay chain. It resets to all-ones, so the bank stays quiet for
  // num_stages_p+1 cycles after reset while the shadow pipeline refills.
  logic [num_stages_p:0] r_freeze;
  logic                  w_en;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) r_freeze <= '1;
    else         r_freeze <= {r_freeze[num_stages_p-1:0], freeze_i};
  end

  assign w_en = ~r_freeze[num_stages_p];

  // Shadow pipeline: an event seen at stage s reaches the attribution point
  // num_stages_p-1-s cycles later.
  logic [num_reasons_p-1:0] w_next [num_stages_p];
  logic [num_reasons_p-1:0] w_attr;

  assign w_next[0] = stage_event_i[0 +: num_reasons_p];

  if (num_stages_p > 1) begin : g_pipe
    logic [num_reasons_p-1:0] r_pipe [num_stages_p-1];

    for (genvar s = 1; s < num_stages_p; s++) begin : g_stage
      assign w_next[s] = r_pipe[s-1] | stage_event_i[s*num_reasons_p +: num_reasons_p];
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i || clear_i) begin
        for (int i = 0; i < num_stages_p - 1; i++) r_pipe[i] <= '0;
      end else begin
        for (int i = 0; i < num_stages_p - 1; i++) r_pipe[i] <= w_next[i];
      end
    end
  end

  assign w_attr = w_next[num_stages_p-1];

  // Lowest set bit wins. An empty vector falls through to reason 0 (unknown).
  logic [addr_width_lp-1:0] w_reason;

  // NOTE: every always_comb output gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    w_reason = '0;
    for (int i = num_reasons_p - 1; i >= 0; i--) begin
      if (w_attr[i]) w_reason = addr_width_lp'(i);
    end
  end

  // One-hot reason increment plus the cycle and instret counters.
  logic [num_cnt_lp-1:0] w_inc;

  always_comb begin
    w_inc = '0;
    if (w_en) begin
      w_inc[cyc_idx_lp] = 1'b1;
      if (instret_i) w_inc[ret_idx_lp] = 1'b1;
      else           w_inc[w_reason]   = 1'b1;
    end
  end

  logic [cnt_width_p-1:0] r_live   [num_cnt_lp];
  logic [cnt_width_p-1:0] r_shadow [num_cnt_lp];
  logic [cnt_width_p-1:0] w_live_inc [num_cnt_lp];
  logic                   w_ovf_hit;
  logic                   r_ovf;

  always_comb begin
    w_ovf_hit = 1'b0;
    for (int i = 0; i < num_cnt_lp; i++) begin
      w_live_inc[i] = r_live[i];
      if (w_inc[i]) begin
`ifdef BP_STALL_COUNTERS_SATURATE_EN
        if (r_live[i] != max_lp)            w_live_inc[i] = r_live[i] + one_lp;
        if (r_live[i] >= (max_lp - one_lp)) w_ovf_hit     = 1'b1;
`else
        w_live_inc[i] = r_live[i] + one_lp;
        if (r_live[i] == max_lp) w_ovf_hit = 1'b1;
`endif
      end
    end
  end

  // NOTE: the counter banks are plain flop arrays (no RAM macro), so they
  // take the asynchronous reset like any other state.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i || clear_i) begin
      for (int i = 0; i < num_cnt_lp; i++) begin
        r_live[i]   <= '0;
        r_shadow[i] <= '0;
      end
      r_ovf <= 1'b0;
    end else if (snapshot_i) begin
      // Shadow captures pre-increment values. Live restarts from this
      // cycle's increments so no cycle is lost across the snapshot.
      for (int i = 0; i < num_cnt_lp; i++) begin
        r_shadow[i] <= r_live[i];
        r_live[i]   <= cnt_width_p'(w_inc[i]);
      end
      r_ovf <= 1'b0;
    end else begin
      for (int i = 0; i < num_cnt_lp; i++) r_live[i] <= w_live_inc[i];
      if (w_ovf_hit) r_ovf <= 1'b1;
    end
  end

  // Read port: one-entry output register. It accepts a new request whenever
  // the held data is empty or being consumed this cycle.
  logic                   r_rd_v;
  logic [cnt_width_p-1:0] r_rd_data;
  logic                   w_rd_ready;
  logic                   w_addr_ok;

  assign w_rd_ready = ~r_rd_v | rd_data_yumi_i;
  assign w_addr_ok  = rd_addr_i < addr_width_lp'(num_cnt_lp);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_rd_v    <= 1'b0;
      r_rd_data <= '0;
    end else if (rd_v_i && w_rd_ready) begin
      r_rd_v    <= 1'b1;
      r_rd_data <= w_addr_ok ? r_shadow[rd_addr_i] : '0;
    end else if (rd_data_yumi_i) begin
      r_rd_v    <= 1'b0;
    end
  end

  assign rd_ready_and_o = w_rd_ready;
  assign rd_data_v_o    = r_rd_v;
  assign rd_data_o      = r_rd_data;
  assign overflow_o     = r_ovf;

endmodule
